// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Entry widths here fix the XLEN/ILEN that ifetch_ctrl is built with.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int FETCH_ILEN = 32;
    localparam logic [FETCH_XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_ILEN-1:0] instr;
    } fetch_entry_t;

    // True when a byte PC lies outside an imem of 2**instrn words or is not word aligned.
    function automatic logic pc_is_bad(input logic [FETCH_XLEN-1:0] pc, input int instrn);
        logic [FETCH_XLEN-1:0] hi;
        hi = pc >> (instrn + 2);
        return (hi != '0) || (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of {pc, instr} fetch entries; flush empties it and wins over push.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, reads imem combinationally and queues {pc, instr} for decode.
// Handshake: an instruction transfers on any rising edge where instr_valid && instr_ready.
module ifetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              INSTRN    = 7,
    parameter int              ILEN      = FETCH_ILEN,
    parameter int              XLEN      = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [INSTRN-1:0] imem_addr,
    input  logic [ILEN-1:0]   imem_instr,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              halt_req,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ILEN-1:0]   instr_out,
    output logic [XLEN-1:0]   instr_pc,
    output logic              fault,
    output logic [1:0]        fetch_state
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_bad;
    logic            redirect_ok;
    logic            redirect_bad;
    logic            buf_push;
    logic            buf_pop;
    logic            buf_flush;
    logic            buf_full;
    logic            buf_empty;
    fetch_entry_t    buf_in;
    fetch_entry_t    buf_head;

    assign imem_addr    = pc_q[INSTRN+1:2];
    assign pc_bad       = pc_is_bad(pc_q, INSTRN);
    assign redirect_ok  = redirect && (state_q != FAULT);
    assign redirect_bad = redirect_ok && (redirect_pc[1:0] != 2'b00);
    assign buf_pop      = instr_valid && instr_ready;
    assign buf_in       = '{pc: pc_q, instr: imem_instr};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_push  = 1'b0;
        buf_flush = 1'b0;

        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (pc_bad) begin
                    state_d = FAULT;
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (!buf_full || buf_pop) begin
                    buf_push = 1'b1;
                    pc_d     = pc_q + XLEN'(4);
                end
            end
            HALT: begin
                if (!halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = FAULT;
        endcase

        // Redirect overrides fetch; a pop in the same cycle still completes at decode.
        if (redirect_ok) begin
            buf_flush = 1'b1;
            buf_push  = 1'b0;
            pc_d      = redirect_pc;
            if (redirect_bad) begin
                state_d = FAULT;
            end else if (state_q == RUN) begin
                state_d = halt_req ? HALT : RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buf #(
        .DEPTH(BUF_DEPTH)
    ) u_fetch_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (buf_push),
        .pop      (buf_pop),
        .flush    (buf_flush),
        .push_data(buf_in),
        .full     (buf_full),
        .empty    (buf_empty),
        .head     (buf_head)
    );

    assign instr_valid = !buf_empty;
    assign instr_out   = instr_valid ? buf_head.instr : '0;
    assign instr_pc    = instr_valid ? buf_head.pc : '0;
    assign fault       = (state_q == FAULT);
    assign fetch_state = state_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: hand-computed expectations plus an in-order transfer scoreboard.
module tb_ifetch_ctrl;
    import fetch_pkg::*;

    localparam int INSTRN = 7;
    localparam int ILEN   = 32;
    localparam int XLEN   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [INSTRN-1:0] imem_addr;
    logic [ILEN-1:0]   imem_instr;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              halt_req;
    logic              instr_valid;
    logic              instr_ready;
    logic [ILEN-1:0]   instr_out;
    logic [XLEN-1:0]   instr_pc;
    logic              fault;
    logic [1:0]        fetch_state;

    logic [ILEN-1:0] imem [1 << INSTRN];
    logic [XLEN-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    ifetch_ctrl #(
        .INSTRN(INSTRN), .ILEN(ILEN), .XLEN(XLEN), .RESET_PC('0), .BUF_DEPTH(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt_req   (halt_req),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .fault      (fault),
        .fetch_state(fetch_state)
    );

    always #5 clk = ~clk;

    assign imem_instr = imem[imem_addr];

    function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Any transfer about to happen at the coming edge must match the next expected pc.
    task automatic sb_transfer();
        logic [XLEN-1:0] e;
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", instr_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e);
                check("sb_instr", instr_out, instr_of(e));
            end
        end
    endtask

    task automatic tick();
        sb_transfer();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt_req    = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        exp_q.delete();
        reset       = 1'b0;
        instr_ready = rdy;
    endtask

    initial begin
        for (int i = 0; i < (1 << INSTRN); i++) begin
            imem[i] = instr_of(XLEN'(i * 4));
        end

        // Reset state and back-to-back stream.
        do_reset(1'b1);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_out", instr_out, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_state", 32'(fetch_state), 0);
        check("rst_addr", 32'(imem_addr), 0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        tick();
        check("t1_idle_valid", 32'(instr_valid), 0);
        check("t1_run_state", 32'(fetch_state), 1);
        tick();
        check("t1_first_valid", 32'(instr_valid), 1);
        check("t1_pc0", instr_pc, 32'h0);
        tick();
        check("t1_pc4", instr_pc, 32'h4);
        tick();
        check("t1_pc8", instr_pc, 32'h8);
        tick();
        check("t1_drain", exp_q.size(), 0);

        // Backpressure fills the buffer, head and address hold still.
        do_reset(1'b0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(instr_valid), 1);
            check("t2_hold_pc", instr_pc, 32'h0);
            tick();
        end
        check("t2_addr_frozen", 32'(imem_addr), 2);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        instr_ready = 1'b1;
        check("t2_rel_pc0", instr_pc, 32'h0);
        tick();
        check("t2_rel_pc4", instr_pc, 32'h4);
        tick();
        check("t2_head8", instr_pc, 32'h8);

        // Redirect with {8,12} buffered: 8 transfers, 12 is dropped.
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        exp_q.push_back(32'h48);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("t3_flush_valid", 32'(instr_valid), 0);
        check("t3_addr_target", 32'(imem_addr), 32'h10);
        tick();
        check("t3_target_valid", 32'(instr_valid), 1);
        check("t3_target_pc", instr_pc, 32'h40);

        // Halt with two entries buffered: drain, no fetch, then resume.
        instr_ready = 1'b0;
        tick();
        check("t4_two_head", instr_pc, 32'h40);
        halt_req    = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("t4_halt_state", 32'(fetch_state), 2);
        check("t4_drain_pc", instr_pc, 32'h44);
        tick();
        check("t4_empty", 32'(instr_valid), 0);
        tick();
        check("t4_no_fetch", 32'(instr_valid), 0);
        check("t4_addr_hold", 32'(imem_addr), 32'h12);
        halt_req = 1'b0;
        tick();
        check("t4_resume_state", 32'(fetch_state), 1);
        tick();
        check("t4_resume_pc", instr_pc, 32'h48);
        tick();
        instr_ready = 1'b0;
        tick();
        check("t4_drain", exp_q.size(), 0);

        // Reset with two entries buffered drops them.
        check("t6_pre_valid", 32'(instr_valid), 1);
        reset = 1'b1;
        tick();
        check("t6_valid", 32'(instr_valid), 0);
        check("t6_state", 32'(fetch_state), 0);
        check("t6_addr", 32'(imem_addr), 0);
        reset       = 1'b0;
        instr_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        tick();
        tick();
        check("t6_restart_pc", instr_pc, 32'h0);
        tick();
        check("t6_next_pc", instr_pc, 32'h4);

        // Misaligned redirect faults; head 4 still transfers that cycle.
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        tick();
        redirect = 1'b0;
        check("t5a_fault", 32'(fault), 1);
        check("t5a_state", 32'(fetch_state), 3);
        for (int i = 0; i < 3; i++) begin
            check("t5a_no_valid", 32'(instr_valid), 0);
            tick();
        end
        check("t5a_drain", exp_q.size(), 0);

        // Walk off the top of imem: 0x1FC delivered, then fault, no wrap.
        do_reset(1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h1F8;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        tick();
        check("t5b_fault", 32'(fault), 1);
        check("t5b_state", 32'(fetch_state), 3);
        check("t5b_head", instr_pc, 32'h1F8);
        exp_q.push_back(32'h1F8);
        exp_q.push_back(32'h1FC);
        instr_ready = 1'b1;
        tick();
        check("t5b_last_pc", instr_pc, 32'h1FC);
        tick();
        check("t5b_empty", 32'(instr_valid), 0);
        tick();
        check("t5b_no_wrap", 32'(instr_valid), 0);
        check("t5b_still_fault", 32'(fault), 1);
        check("t5b_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
